// File: rtl/rv32i_lsu_pkg.sv
// rv32i_lsu_pkg: funct3 codes, FSM state encoding and access-decode helpers
// shared by the load/store unit and its load-alignment datapath.
package rv32i_lsu_pkg;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Byte enables for an access of the size encoded in funct3[1:0] at a byte offset.
  function automatic logic [3:0] byte_enables(input logic [2:0] funct3,
                                              input logic [1:0] offset);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << offset;
      2'b01:   be = 4'b0011 << offset;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // True when funct3 is a legal load/store code and the address is naturally aligned.
  function automatic logic access_ok(input logic       we,
                                     input logic [2:0] funct3,
                                     input logic [1:0] offset);
    logic legal;
    logic aligned;
    if (we) legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    else    legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                    (funct3 == F3_LBU) || (funct3 == F3_LHU);
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~offset[0];
      default: aligned = (offset == 2'b00);
    endcase
    return legal && aligned;
  endfunction

  // Replicate store data across all lanes so the byte enables alone select the target.
  function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                              input logic [31:0] wdata);
    logic [31:0] lanes;
    case (funct3[1:0])
      2'b00:   lanes = {4{wdata[7:0]}};
      2'b01:   lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/rv32i_lsu_if.sv
// Handshake bundles of the load/store unit: the datapath-facing request/response
// side and the single-outstanding data-memory port.

interface rv32i_lsu_dp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        busy;

  // Datapath drives requests
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, busy
  );

  // Load/store unit serves them
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata, busy
  );
endinterface

interface rv32i_lsu_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  // Load/store unit issues memory requests
  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  // Data memory answers them
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/rv32i_load_align.sv
// rv32i_load_align: moves the addressed byte/half of a loaded word down to bit 0
// and sign- or zero-extends it according to the load funct3.
module rv32i_load_align
  import rv32i_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  // Extend the shifted lane by load type; anything else passes the full word
  always_comb begin
    o_result = w_shifted;
    case (i_funct3)
      F3_LB:   o_result = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   o_result = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_LBU:  o_result = {24'd0, w_shifted[7:0]};
      F3_LHU:  o_result = {16'd0, w_shifted[15:0]};
      default: o_result = w_shifted;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// rv32i_lsu: RV32I load/store unit. Accepts one load/store at a time from the
// datapath, rejects illegal or misaligned accesses without touching memory, and
// drives a request/grant/rvalid memory port.
//
//   state | meaning
//   IDLE  | ready for a request
//   REQ   | mem_req held with stable address/data until mem_gnt
//   WAIT  | load granted, waiting for mem_rvalid
//   RESP  | one-cycle resp_valid pulse back to the datapath
module rv32i_lsu
  import rv32i_lsu_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  rv32i_lsu_dp_if.slave   dp,
  rv32i_lsu_mem_if.master mem
);

  lsu_state_e  r_state;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;
  logic [1:0]  r_offset;
  logic [2:0]  r_funct3;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  logic        w_accept;
  logic        w_ok;
  logic [31:0] w_load_result;

  assign w_accept = dp.req_valid && (r_state == ST_IDLE);
  assign w_ok     = access_ok(dp.req_we, dp.req_funct3, dp.req_addr[1:0]);

  rv32i_load_align u_load_align (
    .i_rdata  (mem.mem_rdata),
    .i_offset (r_offset),
    .i_funct3 (r_funct3),
    .o_result (w_load_result)
  );

  // Transaction FSM with all outputs registered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_be     <= 4'd0;
      r_mem_wdata  <= 32'd0;
      r_offset     <= 2'd0;
      r_funct3     <= 3'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (!w_ok) begin
              r_resp_err   <= 1'b1;
              r_resp_valid <= 1'b1;
              r_state      <= ST_RESP;
            end else begin
              r_resp_err  <= 1'b0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= dp.req_we;
              r_mem_addr  <= {dp.req_addr[31:2], 2'b00};
              r_mem_be    <= byte_enables(dp.req_funct3, dp.req_addr[1:0]);
              r_mem_wdata <= dp.req_we ? store_lanes(dp.req_funct3, dp.req_wdata) : 32'd0;
              r_offset    <= dp.req_addr[1:0];
              r_funct3    <= dp.req_funct3;
              r_state     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem.mem_gnt) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_mem_we) begin
              r_resp_valid <= 1'b1;
              r_state      <= ST_RESP;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem.mem_rvalid) begin
            r_resp_rdata <= w_load_result;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dp.req_ready  = (r_state == ST_IDLE);
  assign dp.busy       = (r_state != ST_IDLE);
  assign dp.resp_valid = r_resp_valid;
  assign dp.resp_err   = r_resp_err;
  assign dp.resp_rdata = r_resp_rdata;

  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_be    = r_mem_be;
  assign mem.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_rv32i_lsu.sv
// tb_rv32i_lsu: directed bench for the load/store unit. A transaction-level model
// predicts the outputs every cycle; directed vectors pin the model with literals.
module tb_rv32i_lsu;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  rv32i_lsu_dp_if  dp();
  rv32i_lsu_mem_if mem();

  rv32i_lsu dut (
    .clock   (clock),
    .reset_n (reset_n),
    .dp      (dp),
    .mem     (mem)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  bit          m_busy, m_need_gnt, m_need_data, m_pulse, m_err;
  logic [31:0] m_rdata;
  logic        t_we;
  logic [2:0]  t_f3;
  logic [31:0] t_addr, t_wdata, e_wdata;
  logic [3:0]  e_be;
  int          nbytes;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_need_gnt = 0; m_need_data = 0; m_pulse = 0; m_err = 0;
      m_rdata = 32'd0;
    end else if (m_pulse) begin
      m_pulse = 0;
      m_busy  = 0;
    end else if (!m_busy) begin
      if (dp.req_valid) begin
        bit   legal;
        int   be_int;
        t_we    = dp.req_we;
        t_f3    = dp.req_funct3;
        t_addr  = dp.req_addr;
        t_wdata = dp.req_wdata;
        nbytes  = 1 << t_f3[1:0];
        if (t_we) legal = (t_f3 < 3);
        else      legal = (t_f3 == 0) || (t_f3 == 1) || (t_f3 == 2) || (t_f3 == 4) || (t_f3 == 5);
        legal   = legal && ((t_addr % nbytes) == 0);
        be_int  = ((1 << nbytes) - 1) << (t_addr % 4);
        e_be    = be_int[3:0];
        if (!t_we)            e_wdata = 32'd0;
        else if (nbytes == 1) e_wdata = {24'd0, t_wdata[7:0]} * 32'h0101_0101;
        else if (nbytes == 2) e_wdata = {16'd0, t_wdata[15:0]} * 32'h0001_0001;
        else                  e_wdata = t_wdata;
        m_busy = 1;
        m_err  = !legal;
        if (!legal) m_pulse = 1;
        else        m_need_gnt = 1;
      end
    end else if (m_need_gnt) begin
      if (mem.mem_gnt) begin
        m_need_gnt = 0;
        if (t_we) m_pulse = 1;
        else      m_need_data = 1;
      end
    end else if (m_need_data) begin
      if (mem.mem_rvalid) begin
        logic [31:0] v;
        v = mem.mem_rdata >> (8 * (t_addr % 4));
        if (nbytes == 1) begin
          v = v & 32'hFF;
          if (!t_f3[2] && v >= 128) v = v - 32'd256;
        end else if (nbytes == 2) begin
          v = v & 32'hFFFF;
          if (!t_f3[2] && v >= 32768) v = v - 32'd65536;
        end
        m_rdata     = v;
        m_need_data = 0;
        m_pulse     = 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (reset_n) begin
      chk("req_ready", 32'(dp.req_ready), 32'(!m_busy));
      chk("busy", 32'(dp.busy), 32'(m_busy));
      chk("mem_req", 32'(mem.mem_req), 32'(m_need_gnt));
      if (m_need_gnt) begin
        chk("mem_addr", mem.mem_addr, {t_addr[31:2], 2'b00});
        chk("mem_be", 32'(mem.mem_be), 32'(e_be));
        chk("mem_we", 32'(mem.mem_we), 32'(t_we));
        chk("mem_wdata", mem.mem_wdata, e_wdata);
      end
      chk("resp_valid", 32'(dp.resp_valid), 32'(m_pulse));
      if (m_pulse) chk("resp_err", 32'(dp.resp_err), 32'(m_err));
      chk("resp_rdata", dp.resp_rdata, m_rdata);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(dp.req_ready), 32'd1);
    chk({tag, "_busy"}, 32'(dp.busy), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem.mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem.mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem.mem_addr, 32'd0);
    chk({tag, "_mem_be"}, 32'(mem.mem_be), 32'd0);
    chk({tag, "_mem_wdata"}, mem.mem_wdata, 32'd0);
    chk({tag, "_resp_valid"}, 32'(dp.resp_valid), 32'd0);
    chk({tag, "_resp_err"}, 32'(dp.resp_err), 32'd0);
    chk({tag, "_resp_rdata"}, dp.resp_rdata, 32'd0);
  endtask

  // Issue one request and play memory with the given grant/rvalid stall counts.
  task automatic run_txn(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int gnt_wait, input int rv_wait,
                         input bit spam, input int exp_lat,
                         output logic [31:0] c_addr, output logic [3:0] c_be,
                         output logic [31:0] c_wdata, output logic c_we,
                         output bit c_req, output logic c_err);
    int gcnt, rcnt, lat;
    bit dphase;
    gcnt = gnt_wait; rcnt = rv_wait; dphase = 0; lat = -1;
    c_addr = 0; c_be = 0; c_wdata = 0; c_we = 0; c_req = 0; c_err = 0;
    @(negedge clock);
    dp.req_valid = 1; dp.req_we = we; dp.req_funct3 = f3;
    dp.req_addr = addr; dp.req_wdata = wdata;
    @(posedge clock);
    #1;
    if (spam) begin
      dp.req_we = 1'b0; dp.req_funct3 = 3'b010; dp.req_addr = 32'h300;
    end else begin
      dp.req_valid = 0;
    end
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clock);
      if (dp.resp_valid) begin
        lat   = c;
        c_err = dp.resp_err;
      end else begin
        if (mem.mem_req && !c_req) begin
          c_req = 1; c_addr = mem.mem_addr; c_be = mem.mem_be;
          c_wdata = mem.mem_wdata; c_we = mem.mem_we;
        end
        mem.mem_rvalid = 0;
        if (dphase) begin
          if (rcnt == 0) begin
            mem.mem_rvalid = 1; mem.mem_rdata = rdata; dphase = 0;
          end else rcnt--;
        end
        mem.mem_gnt = 0;
        if (mem.mem_req) begin
          if (gcnt == 0) begin
            mem.mem_gnt = 1;
            if (!we) dphase = 1;
          end else begin
            gcnt--;
            if (spam) mem.mem_rvalid = 1;
          end
        end
      end
    end
    mem.mem_gnt = 0; mem.mem_rvalid = 0; dp.req_valid = 0;
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_be;
  logic        c_we, c_err;
  bit          c_req;
  bit          seen;

  initial begin
    dp.req_valid = 0; dp.req_we = 0; dp.req_funct3 = 0; dp.req_addr = 0; dp.req_wdata = 0;
    mem.mem_gnt = 0; mem.mem_rvalid = 0; mem.mem_rdata = 0;
    repeat (2) @(posedge clock);
    #1;
    chk_reset("por");
    @(negedge clock);
    reset_n = 1;

    run_txn("lw100", 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0, 3,
            c_addr, c_be, c_wdata, c_we, c_req, c_err);
    chk("lw100_addr", c_addr, 32'h100);
    chk("lw100_be", 32'(c_be), 32'hF);
    chk("lw100_rdata", dp.resp_rdata, 32'hDEADBEEF);

    run_txn("lb103", 0, 3'b000, 32'h103, 0, 32'h80FF_FFFF, 0, 0, 0, 3,
            c_addr, c_be, c_wdata, c_we, c_req, c_err);
    chk("lb103_be", 32'(c_be), 32'h8);
    chk("lb103_rdata", dp.resp_rdata, 32'hFFFF_FF80);

    run_txn("lbu103", 0, 3'b100, 32'h103, 0, 32'h80FF_FFFF, 0, 0, 0, 3,
            c_addr, c_be, c_wdata, c_we, c_req, c_err);
    chk("lbu103_rdata", dp.resp_rdata, 32'h0000_0080);

    run_txn("sh202", 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 0, 0, 0, 2,
            c_addr, c_be, c_wdata, c_we, c_req, c_err);
    chk("sh202_addr", c_addr, 32'h200);
    chk("sh202_be", 32'(c_be), 32'hC);
    chk("sh202_wdata", c_wdata, 32'hABCDABCD);
    chk("sh202_we", 32'(c_we), 32'd1);

    run_txn("lw101", 0, 3'b010, 32'h101, 0, 32'h5555_5555, 0, 0, 0, 1,
            c_addr, c_be, c_wdata, c_we, c_req, c_err);
    chk("lw101_err", 32'(c_err), 32'd1);
    chk("lw101_no_mem_req", 32'(c_req), 32'd0);
    chk("lw101_rdata_kept", dp.resp_rdata, 32'h0000_0080);

    run_txn("sw_stall", 1, 3'b010, 32'h40, 32'h11223344, 0, 3, 0, 1, 5,
            c_addr, c_be, c_wdata, c_we, c_req, c_err);
    chk("sw_stall_addr", c_addr, 32'h40);
    chk("sw_stall_be", 32'(c_be), 32'hF);
    chk("sw_stall_wdata", c_wdata, 32'h11223344);

    run_txn("lh102", 0, 3'b001, 32'h102, 0, 32'h8001_1234, 0, 2, 0, 5,
            c_addr, c_be, c_wdata, c_we, c_req, c_err);
    chk("lh102_be", 32'(c_be), 32'hC);
    chk("lh102_rdata", dp.resp_rdata, 32'hFFFF_8001);

    run_txn("lhu100", 0, 3'b101, 32'h100, 0, 32'h1234_F00D, 0, 0, 0, 3,
            c_addr, c_be, c_wdata, c_we, c_req, c_err);
    chk("lhu100_be", 32'(c_be), 32'h3);
    chk("lhu100_rdata", dp.resp_rdata, 32'h0000_F00D);

    run_txn("sb001", 1, 3'b000, 32'h001, 32'h0000_00A5, 0, 0, 0, 0, 2,
            c_addr, c_be, c_wdata, c_we, c_req, c_err);
    chk("sb001_be", 32'(c_be), 32'h2);
    chk("sb001_wdata", c_wdata, 32'hA5A5A5A5);

    run_txn("lh001", 0, 3'b001, 32'h001, 0, 0, 0, 0, 0, 1,
            c_addr, c_be, c_wdata, c_we, c_req, c_err);
    chk("lh001_err", 32'(c_err), 32'd1);

    run_txn("ld_f3_011", 0, 3'b011, 32'h000, 0, 0, 0, 0, 0, 1,
            c_addr, c_be, c_wdata, c_we, c_req, c_err);
    chk("ld_f3_011_err", 32'(c_err), 32'd1);
    chk("ld_f3_011_no_mem_req", 32'(c_req), 32'd0);

    run_txn("st_f3_011", 1, 3'b011, 32'h000, 32'hFFFF_FFFF, 0, 0, 0, 0, 1,
            c_addr, c_be, c_wdata, c_we, c_req, c_err);
    chk("st_f3_011_err", 32'(c_err), 32'd1);

    run_txn("lb001", 0, 3'b000, 32'h001, 0, 32'h0000_7F00, 0, 0, 0, 3,
            c_addr, c_be, c_wdata, c_we, c_req, c_err);
    chk("lb001_err_cleared", 32'(c_err), 32'd0);
    chk("lb001_rdata", dp.resp_rdata, 32'h0000_007F);

    // Reset while a load is waiting for its data
    @(negedge clock);
    dp.req_valid = 1; dp.req_we = 0; dp.req_funct3 = 3'b010; dp.req_addr = 32'h10;
    @(posedge clock);
    #1 dp.req_valid = 0;
    @(negedge clock);
    mem.mem_gnt = 1;
    @(negedge clock);
    mem.mem_gnt = 0;
    chk("wait_busy", 32'(dp.busy), 32'd1);
    chk("wait_mem_req", 32'(mem.mem_req), 32'd0);
    reset_n = 0;
    #1;
    chk_reset("mid_reset");
    @(negedge clock);
    reset_n = 1;
    mem.mem_rvalid = 1; mem.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clock);
    mem.mem_rvalid = 0;
    seen = 0;
    repeat (4) begin
      @(negedge clock);
      if (dp.resp_valid) seen = 1;
    end
    chk("late_rvalid_no_resp", 32'(seen), 32'd0);
    chk("late_rvalid_rdata", dp.resp_rdata, 32'd0);

    run_txn("lw_after_reset", 0, 3'b010, 32'h8, 0, 32'h0BAD_F00D, 0, 0, 0, 3,
            c_addr, c_be, c_wdata, c_we, c_req, c_err);
    chk("lw_after_reset_addr", c_addr, 32'h8);
    chk("lw_after_reset_rdata", dp.resp_rdata, 32'h0BAD_F00D);

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_lsu.md
# rv32i_lsu

Load/store unit for the RV32I core: sits directly downstream of the datapath ALU. It takes the effective address (ALU result), store data (rs2 value) and funct3 of a load/store instruction. It drives a single-outstanding request/grant/rvalid data-memory port and returns the aligned, sign- or zero-extended load result for write-back. Misaligned or illegal accesses are rejected without touching memory; the datapath stalls on `busy` until `resp_valid`.

## Interface
Parameters:
- none; all widths fixed at RV32 (32-bit address and data, 4 byte lanes).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  datapath presents a load/store.
- `req_ready`  out  1  unit can accept a request; high exactly in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  instruction funct3.
- `req_addr`  in  32  effective byte address.
- `req_wdata`  in  32  store data (rs2).
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_err`  out  1  valid with `resp_valid`: misaligned or illegal funct3.
- `resp_rdata`  out  32  extended load data; holds until the next load completes.
- `busy`  out  1  high in any state other than IDLE.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write strobe.
- `mem_addr`  out  32  word address, bits [1:0] always 0.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_gnt`  in  1  memory accepted the request this cycle.
- `mem_rvalid`  in  1  load data valid.
- `mem_rdata`  in  32  load word.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - A request is accepted on `req_valid && req_ready`.
  - Illegal funct3 (load 011/110/111; store ≥011) or misalignment (half with addr[0]=1; word with addr[1:0]≠0): go to RESP with `resp_err`=1; no memory access.
  - Otherwise: register addr, offset, funct3, `mem_be` and `mem_wdata`, then go to REQ.
- Byte enables:
  - byte: 0001<<addr[1:0]
  - half: 0011<<addr[1:0]
  - word: 1111
- Store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
  - `mem_wdata` = 0 for loads.
- REQ: `mem_req`=1. All mem_* outputs are held stable until `mem_gnt`. On gnt, a store goes to RESP and a load goes to WAIT.
- WAIT: on `mem_rvalid`, `resp_rdata` ← `mem_rdata >> (8*offset)`, then:
  - LB / LH: sign-extend from bit 7 / 15.
  - LBU / LHU: zero-extend.
  - LW: full word.
  - Then go to RESP.
- RESP: `resp_valid`=1 for one cycle, then IDLE.
- `mem_rvalid` in IDLE, REQ or RESP is ignored; `req_valid` while busy is ignored (the datapath must hold the request).
- `resp_err` is cleared on every accepted request.

## Timing
- Reset (async assert): state IDLE; every output 0 except `req_ready`=1. `resp_rdata`=0.
- Reset mid-transaction: `mem_req` drops immediately; a late `mem_rvalid` after release is ignored.
- Request accepted at edge T; `mem_req` is registered and is high from T+1.
- Zero-wait memory (gnt at T+1, rvalid at T+2):
  - load: `resp_valid` at T+3
  - store: `resp_valid` at T+2
  - error: `resp_valid` at T+1
- Each stall cycle of gnt or rvalid adds one cycle.
- At most one transaction is outstanding. Memory never asserts rvalid in the same cycle as the gnt of the same load.

## Structure
- Package `rv32i_lsu_pkg`:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW)
  - state encoding
  - a function returning the byte enables for (funct3, offset)
  - a function returning the legal/aligned check
- Sub-module `rv32i_load_align`: combinational shift plus sign/zero extension (inputs rdata, offset, funct3; output 32-bit result). It is unit-tested separately.

## Test plan
- LW at 0x100, zero-wait memory, rdata 0xDEADBEEF → `mem_addr` 0x100, `mem_be` 1111, `resp_valid` at T+3, `resp_rdata` 0xDEADBEEF.
- LB at 0x103 with rdata 0x80FF_FFFF → `mem_be` 1000, `resp_rdata` 0xFFFF_FF80; LBU at the same address → 0x0000_0080.
- SH at 0x202, wdata 0x1234ABCD → `mem_addr` 0x200, `mem_be` 1100, `mem_wdata` 0xABCDABCD, `mem_we`=1, `resp_valid` at T+2.
- LW at 0x101 → `resp_err`=1 and `resp_valid` at T+1, `mem_req` never asserted; `resp_rdata` keeps its previous value.
- SW with `mem_gnt` held low 3 cycles → mem_* outputs are stable throughout, `req_ready`=0, and a second `req_valid` is not accepted; `resp_valid` follows the gnt by one cycle.
- `reset_n` pulsed low while in WAIT, then `mem_rvalid` arrives → outputs zero, `req_ready`=1 immediately, no `resp_valid` generated.
